// File: rtl/pp_pkg.sv
// Shared types and constants for the pixel preprocess mode controller.
package pp_pkg;

    localparam logic MODE_PASSTHROUGH = 1'b0;
    localparam logic MODE_GREYSCALE   = 1'b1;

    localparam int FRAME_PIXELS_DEFAULT = 307200;

    localparam logic [1:0] ST_WAIT_SOF = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_PEND     = 2'd2;
    localparam logic [1:0] ST_DRAIN    = 2'd3;

    typedef enum logic [1:0] {
        WAIT_SOF = ST_WAIT_SOF,
        RUN      = ST_RUN,
        PEND     = ST_PEND,
        DRAIN    = ST_DRAIN
    } state_t;

endpackage

// File: rtl/pp_sat_counter.sv
// Saturating up-counter with a clear that either wins outright or reloads
// the counter with the coincident increment (start-of-frame style).
module pp_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    input  logic         clr,
    input  logic         clr_prio,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= (clr_prio || !inc) ? '0 : ONE;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pp_mode_ctrl.sv
// Frame-synchronous mode sequencer: applies passthrough/greyscale changes only
// at start-of-frame after draining the greyscale pipeline, and keeps frame stats.
module pp_mode_ctrl
    import pp_pkg::*;
#(
    parameter int   FRAME_PIXELS = FRAME_PIXELS_DEFAULT,
    parameter int   PIX_CNT_W    = 19,
    parameter int   PIPE_LAT     = 2,
    parameter int   DROP_CNT_W   = 16,
    parameter logic DEFAULT_MODE = MODE_PASSTHROUGH
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_vsync,
    input  logic                  i_mode_req,
    input  logic                  i_mode_req_valid,
    input  logic                  i_pix_valid,
    input  logic                  i_pix_drop,
    input  logic                  i_clr_stats,
    output logic                  o_mode,
    output logic                  o_hold,
    output logic                  o_pending,
    output logic                  o_frame_done,
    output logic [PIX_CNT_W-1:0]  o_frame_pixels,
    output logic                  o_frame_err,
    output logic [15:0]           o_frame_cnt,
    output logic [DROP_CNT_W-1:0] o_drop_cnt
);

    localparam int DRAIN_W = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
    localparam logic [DRAIN_W-1:0]   DRAIN_LOAD   = PIPE_LAT[DRAIN_W-1:0];
    localparam logic [PIX_CNT_W-1:0] FRAME_TARGET = FRAME_PIXELS[PIX_CNT_W-1:0];

    state_t               state;
    logic                 vsync_q;
    logic                 sof;
    logic                 pend_mode;
    logic                 nxt_mode;
    logic                 nxt_valid;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [PIX_CNT_W-1:0] pix_cnt;
    logic                 frame_end;

    assign sof       = i_vsync & ~vsync_q;
    assign frame_end = sof && (state != WAIT_SOF);

    // A request arriving mid-drain is parked in nxt_mode and becomes the next pending change.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state     <= WAIT_SOF;
            vsync_q   <= 1'b1;
            o_mode    <= DEFAULT_MODE;
            o_hold    <= 1'b1;
            o_pending <= 1'b0;
            pend_mode <= DEFAULT_MODE;
            nxt_mode  <= DEFAULT_MODE;
            nxt_valid <= 1'b0;
            drain_cnt <= '0;
        end else begin
            vsync_q <= i_vsync;
            case (state)
                WAIT_SOF: begin
                    if (sof) begin
                        state  <= RUN;
                        o_hold <= 1'b0;
                    end
                end
                RUN: begin
                    if (i_mode_req_valid && (i_mode_req != o_mode)) begin
                        pend_mode <= i_mode_req;
                        o_pending <= 1'b1;
                        state     <= PEND;
                    end
                end
                PEND: begin
                    if (i_mode_req_valid && (i_mode_req == o_mode)) begin
                        o_pending <= 1'b0;
                        state     <= RUN;
                    end else begin
                        if (i_mode_req_valid) pend_mode <= i_mode_req;
                        if (sof) begin
                            state     <= DRAIN;
                            o_hold    <= 1'b1;
                            drain_cnt <= DRAIN_LOAD;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        o_mode    <= pend_mode;
                        o_hold    <= 1'b0;
                        nxt_valid <= 1'b0;
                        if (i_mode_req_valid) begin
                            pend_mode <= i_mode_req;
                            state     <= PEND;
                        end else if (nxt_valid) begin
                            pend_mode <= nxt_mode;
                            state     <= PEND;
                        end else begin
                            o_pending <= 1'b0;
                            state     <= RUN;
                        end
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                        if (i_mode_req_valid) begin
                            nxt_mode  <= i_mode_req;
                            nxt_valid <= 1'b1;
                        end
                    end
                end
                default: state <= WAIT_SOF;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_frame_done   <= 1'b0;
            o_frame_pixels <= '0;
            o_frame_err    <= 1'b0;
            o_frame_cnt    <= '0;
        end else begin
            o_frame_done <= frame_end;
            if (frame_end) begin
                o_frame_pixels <= pix_cnt;
                o_frame_err    <= (pix_cnt != FRAME_TARGET);
            end
            if (i_clr_stats) o_frame_cnt <= '0;
            else if (frame_end) o_frame_cnt <= o_frame_cnt + 16'd1;
        end
    end

    // On SOF the pixel counter restarts with the coincident pixel; before the first SOF it stays 0.
    pp_sat_counter #(.W(PIX_CNT_W)) u_pix_cnt (
        .clk      (i_clk),
        .rstn     (i_rstn),
        .inc      (i_pix_valid),
        .clr      (sof || (state == WAIT_SOF)),
        .clr_prio (~sof),
        .count    (pix_cnt)
    );

    pp_sat_counter #(.W(DROP_CNT_W)) u_drop_cnt (
        .clk      (i_clk),
        .rstn     (i_rstn),
        .inc      (i_pix_drop),
        .clr      (i_clr_stats),
        .clr_prio (1'b1),
        .count    (o_drop_cnt)
    );

endmodule

// File: doc/pp_mode_ctrl.md
Name: pp_mode_ctrl

Overview:
Frame-synchronous sequencer for the pixel preprocess datapath (capture FIFO -> greyscale -> output FIFO).
- Accepts asynchronous-in-time mode-change requests (passthrough/greyscale) and applies them only at a start-of-frame.
- Holds capture-FIFO reads while the greyscale pipeline drains, so no frame is ever mixed-mode.
- Also keeps per-frame pixel, frame and drop statistics for debug readout.

Parameters:
FRAME_PIXELS, 307200, expected pixels per frame (640x480)
PIX_CNT_W, 19, pixel counter width; must hold FRAME_PIXELS
PIPE_LAT, 2, greyscale pipeline latency in cycles; DRAIN length = PIPE_LAT+1
DROP_CNT_W, 16, drop counter width
DEFAULT_MODE, 0, mode applied out of reset (0 = passthrough, 1 = greyscale)

Ports:
i_clk  in  1  clock
i_rstn  in  1  synchronous active-low reset
i_vsync  in  1  frame sync, already synchronous to i_clk; rising edge = SOF
i_mode_req  in  1  requested mode
i_mode_req_valid  in  1  one-cycle strobe qualifying i_mode_req
i_pix_valid  in  1  pixel entered the datapath (capture FIFO read data valid)
i_pix_drop  in  1  pixel discarded because the output FIFO was almost-full
i_clr_stats  in  1  one-cycle strobe that clears the drop counter and frame counter
o_mode  out  1  applied mode driven to the datapath mode select
o_hold  out  1  1 = datapath must not issue capture-FIFO reads
o_pending  out  1  a mode change is latched and awaiting SOF
o_frame_done  out  1  one-cycle pulse at each SOF after the first
o_frame_pixels  out  PIX_CNT_W  pixel count of the frame just ended; valid with o_frame_done, held until the next pulse
o_frame_err  out  1  valid with o_frame_done: o_frame_pixels != FRAME_PIXELS
o_frame_cnt  out  16  completed frames, wraps
o_drop_cnt  out  DROP_CNT_W  dropped pixels, saturating

Behaviour:
- Reset values (i_rstn=0 at posedge):
  - o_mode = DEFAULT_MODE; o_hold = 1.
  - o_pending, o_frame_done, o_frame_err = 0; all counters = 0; state = WAIT_SOF.
  - vsync edge register = 1, so vsync held high through reset does not produce a false SOF.
- SOF = i_vsync & ~vsync_q. Detected in cycle N; the state changes at the N+1 edge.
- States:
  - WAIT_SOF: o_hold = 1; wait for the first SOF, then -> RUN. No o_frame_done is generated.
  - RUN: o_hold = 0. A request whose value differs from o_mode latches pend_mode and sets o_pending -> PEND. A request equal to o_mode is ignored.
  - PEND: o_hold = 0.
    - A new request overwrites pend_mode (last wins).
    - A request equal to o_mode cancels the change: o_pending = 0 -> RUN.
    - On SOF -> DRAIN.
  - DRAIN: o_hold = 1 for exactly PIPE_LAT+1 cycles (down-counter). On the final cycle: o_mode <= pend_mode, o_pending <= 0, -> RUN.
    - A request arriving in DRAIN is latched as a new pending change for the following SOF; o_pending stays 1 and the state returns to PEND instead of RUN.
    - A SOF arriving in DRAIN is counted for statistics only; it does not restart the drain.
- o_mode only changes on the DRAIN exit edge; never mid-frame.
- Pixel counting:
  - pix_cnt increments on i_pix_valid and saturates at all-ones.
  - On SOF: o_frame_pixels <= pix_cnt, and pix_cnt <= i_pix_valid, so a pixel coincident with SOF belongs to the new frame.
  - o_frame_done pulses 1 cycle after SOF on every SOF except the first after reset. o_frame_err is computed from the captured count.
  - o_frame_cnt increments with each o_frame_done.
- Drop counting: o_drop_cnt increments on i_pix_drop and saturates at 2^DROP_CNT_W-1.
  - i_clr_stats zeroes o_drop_cnt and o_frame_cnt.
  - Clear wins over a simultaneous increment: the result is 0.
- Counting is independent of state; pixels reported during hold still count. In WAIT_SOF pix_cnt is held at 0.
- Reset mid-frame or mid-DRAIN: immediate return to the reset values; the pending request is lost.

Decomposition:
- Package pp_pkg:
  - MODE_PASSTHROUGH = 1'b0, MODE_GREYSCALE = 1'b1
  - state encoding localparams WAIT_SOF/RUN/PEND/DRAIN
  - FRAME_PIXELS default
- Sub-module pp_sat_counter (parameter W; inputs inc, clr, clr-priority; saturating output). Instantiated for pix_cnt and drop_cnt. The frame counter is a plain wrapping register.

Test Plan:
- Reset with i_vsync=1, then vsync low, then a rising edge -> no SOF during reset; o_hold 1->0 one cycle after the first SOF; no o_frame_done.
- Request greyscale mid-frame (o_mode=0) -> o_pending=1, o_mode stays 0 until the next SOF; o_hold=1 for exactly 3 cycles; o_mode=1 and o_pending=0 on exit.
- Requests 1 then 0 within one frame while o_mode=0 -> o_pending drops to 0; no DRAIN at the next SOF; o_mode stays 0.
- Frame of 307200 i_pix_valid pulses, then SOF -> o_frame_done pulse, o_frame_pixels=307200, o_frame_err=0. Frame of 307199 pulses -> o_frame_err=1, o_frame_cnt incremented.
- i_pix_valid coincident with SOF -> previous frame count excludes that pixel; new frame starts at 1.
- DROP_CNT_W=4, 20 i_pix_drop pulses -> o_drop_cnt=15 (saturated). i_clr_stats with i_pix_drop in the same cycle -> o_drop_cnt=0.
